mux_arb_2: RTL and testbench

MUX_ARB_2 -- requirements
Module: mux_arb_2

---
 rtl/mux_arb_2.sv | 92 +++++++++
 tb/tb_mux_arb_2.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_2.sv
// Two-requester packet arbiter sharing one ready/valid channel.
// Grants are held for a whole packet and alternate round-robin at packet boundaries.
module mux_arb_2 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            in_valid,
  input  logic [2*DATA_W-1:0]   in_data,
  input  logic [1:0]            in_last,
  output logic [1:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   sel_nxt;
  logic   gnt_idx;
  logic   eop_xfer;

  assign gnt_idx  = (state == GNT1);
  assign eop_xfer = in_valid[gnt_idx] && out_ready && in_last[gnt_idx];

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    out_valid      = 1'b0;
    in_ready       = 2'b00;
    busy           = 1'b0;
    out_data       = sel ? in_data[DATA_W +: DATA_W] : in_data[0 +: DATA_W];
    out_last       = in_last[sel];

    case (state)
      IDLE: begin
        case (in_valid)
          2'b01:   state_nxt = GNT0;
          2'b10:   state_nxt = GNT1;
          2'b11:   state_nxt = last_grant ? GNT0 : GNT1;
          default: state_nxt = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        busy              = 1'b1;
        out_valid         = in_valid[gnt_idx];
        in_ready[gnt_idx] = out_ready;
        if (eop_xfer) begin
          last_grant_nxt = gnt_idx;
          // The current requester necessarily had valid high, so it keeps the
          // grant unless the other side is waiting.
          if (in_valid[!gnt_idx])
            state_nxt = gnt_idx ? GNT0 : GNT1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sel is registered alongside the state so it is a clean flop output.
  always_comb begin
    case (state_nxt)
      GNT0:    sel_nxt = 1'b0;
      GNT1:    sel_nxt = 1'b1;
      default: sel_nxt = sel;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      sel        <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_mux_arb_2.sv
// Directed self-checking bench for mux_arb_2: reset, grants, round-robin,
// backpressure, reset mid-packet and valid gaps.
module tb_mux_arb_2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_last;
  logic [1:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        sel;
  logic        busy;
  logic [4:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // {out_valid, in_ready[1:0], sel, busy}
  assign status = {out_valid, in_ready, sel, busy};

  mux_arb_2 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] l, input logic rdy);
    in_valid  = v;
    in_data   = {d1, d0};
    in_last   = l;
    out_ready = rdy;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    step;
    step;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] mk(input int i, input int p, input int b);
    logic [7:0] r;
    r = {i[0], p[2:0], b[3:0]};
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(2'b11, 8'h11, 8'h22, 2'b11, 1'b1);
    step;
    step;
    checks++;
    if (status !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL reset_status got %b want %b", status, 5'b0_00_0_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    drive(2'b01, 8'hA5, 8'h00, 2'b01, 1'b1);
    checks++;
    if (status !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL single_idle got %b want %b", status, 5'b0_00_0_0);
    end
    step;
    checks++;
    if (status !== 5'b1_01_0_1) begin
      errors++;
      $display("FAIL single_grant got %b want %b", status, 5'b1_01_0_1);
    end
    checks++;
    if ({out_data, out_last} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_data got %h/%b want a5/1", out_data, out_last);
    end
    step;
    drive(2'b00, 8'hA5, 8'h00, 2'b00, 1'b1);
    checks++;
    if ({out_valid, sel, in_ready[1]} !== 3'b000) begin
      errors++;
      $display("FAIL single_after got %b want %b", {out_valid, sel, in_ready[1]}, 3'b000);
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    drive(2'b11, 8'h11, 8'h22, 2'b11, 1'b1);
    checks++;
    if (status !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL simul_idle got %b want %b", status, 5'b0_00_0_0);
    end
    step;
    checks++;
    if ({status, out_data} !== {5'b1_01_0_1, 8'h11}) begin
      errors++;
      $display("FAIL simul_first got %b/%h want 10101/11", status, out_data);
    end
    step;
    drive(2'b10, 8'h11, 8'h22, 2'b11, 1'b1);
    checks++;
    if ({status, out_data} !== {5'b1_10_1_1, 8'h22}) begin
      errors++;
      $display("FAIL simul_second got %b/%h want 11011/22", status, out_data);
    end
    step;
    drive(2'b00, 8'h11, 8'h22, 2'b00, 1'b1);
    checks++;
    if ({out_valid, sel} !== 2'b01) begin
      errors++;
      $display("FAIL simul_after got %b want %b", {out_valid, sel}, 2'b01);
    end
  endtask

  task automatic test_round_robin;
    int         b[2];
    int         p[2];
    int         ex;
    logic       active;
    logic [4:0] exp_status;
    b = '{0, 0};
    p = '{0, 0};
    ex = 0;
    active = 1'b0;
    do_reset;
    for (int cyc = 0; cyc < 25; cyc++) begin
      drive(2'b11, mk(0, p[0], b[0]), mk(1, p[1], b[1]), {b[1] == 2, b[0] == 2}, 1'b1);
      if (!active) begin
        checks++;
        if (status !== 5'b0_00_0_0) begin
          errors++;
          $display("FAIL rr_idle got %b want %b", status, 5'b0_00_0_0);
        end
      end else begin
        exp_status = {1'b1, (ex == 1) ? 2'b10 : 2'b01, ex == 1, 1'b1};
        checks++;
        if (status !== exp_status) begin
          errors++;
          $display("FAIL rr_status cyc %0d got %b want %b", cyc, status, exp_status);
        end
        checks++;
        if (out_data !== mk(ex, p[ex], b[ex])) begin
          errors++;
          $display("FAIL rr_data cyc %0d got %h want %h", cyc, out_data, mk(ex, p[ex], b[ex]));
        end
        b[ex]++;
        if (b[ex] == 3) begin
          b[ex] = 0;
          p[ex]++;
          ex = 1 - ex;
        end
      end
      active = 1'b1;
      step;
    end
  endtask

  task automatic test_backpressure;
    logic       rdy_pat[6];
    int         beat;
    int         dut_xfers;
    logic [4:0] exp_status;
    rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    beat      = 0;
    dut_xfers = 0;
    do_reset;
    drive(2'b10, 8'h0F, 8'hB0, 2'b00, 1'b1);
    step;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 8'h0F, 8'hB0 + 8'(beat), {beat == 3, 1'b0}, rdy_pat[k]);
      exp_status = {1'b1, rdy_pat[k] ? 2'b10 : 2'b00, 1'b1, 1'b1};
      checks++;
      if ({status, out_data} !== {exp_status, 8'hB0 + 8'(beat)}) begin
        errors++;
        $display("FAIL bp_beat k %0d got %b/%h want %b/%h", k, status, out_data,
                 exp_status, 8'hB0 + 8'(beat));
      end
      if (out_valid && out_ready && sel) dut_xfers++;
      if (rdy_pat[k]) beat++;
      step;
    end
    checks++;
    if (dut_xfers !== 4) begin
      errors++;
      $display("FAIL bp_count got %0d want 4", dut_xfers);
    end
    drive(2'b01, 8'h0F, 8'hB0, 2'b00, 1'b1);
    checks++;
    if ({status, out_data} !== {5'b1_01_0_1, 8'h0F}) begin
      errors++;
      $display("FAIL bp_handoff got %b/%h want 10101/0f", status, out_data);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive(2'b10, 8'h0F, 8'hC0, 2'b00, 1'b1);
    step;
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 8'h0F, 8'hC0 + 8'(k), 2'b00, 1'b1);
      checks++;
      if ({status, out_data} !== {5'b1_10_1_1, 8'hC0 + 8'(k)}) begin
        errors++;
        $display("FAIL rmid_beat %0d got %b/%h want 11011/%h", k, status, out_data,
                 8'hC0 + 8'(k));
      end
      step;
    end
    rst = 1'b1;
    drive(2'b11, 8'h0F, 8'hC2, 2'b00, 1'b1);
    step;
    rst = 1'b0;
    checks++;
    if (status !== 5'b0_00_0_0) begin
      errors++;
      $display("FAIL rmid_reset got %b want %b", status, 5'b0_00_0_0);
    end
    step;
    checks++;
    if ({status, out_data} !== {5'b1_01_0_1, 8'h0F}) begin
      errors++;
      $display("FAIL rmid_regrant got %b/%h want 10101/0f", status, out_data);
    end
  endtask

  task automatic test_valid_gap;
    do_reset;
    drive(2'b11, 8'hD0, 8'hE0, 2'b00, 1'b1);
    step;
    checks++;
    if ({status, out_data} !== {5'b1_01_0_1, 8'hD0}) begin
      errors++;
      $display("FAIL gap_beat0 got %b/%h want 10101/d0", status, out_data);
    end
    step;
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 8'hD1, 8'hE0, 2'b00, 1'b1);
      checks++;
      if (status !== 5'b0_01_0_1) begin
        errors++;
        $display("FAIL gap_hold %0d got %b want %b", k, status, 5'b0_01_0_1);
      end
      step;
    end
    drive(2'b11, 8'hD1, 8'hE0, 2'b00, 1'b1);
    checks++;
    if ({status, out_data} !== {5'b1_01_0_1, 8'hD1}) begin
      errors++;
      $display("FAIL gap_beat1 got %b/%h want 10101/d1", status, out_data);
    end
    step;
    drive(2'b11, 8'hD2, 8'hE0, 2'b01, 1'b1);
    checks++;
    if ({status, out_data, out_last} !== {5'b1_01_0_1, 8'hD2, 1'b1}) begin
      errors++;
      $display("FAIL gap_beat2 got %b/%h/%b want 10101/d2/1", status, out_data, out_last);
    end
    step;
    drive(2'b11, 8'hD0, 8'hE0, 2'b10, 1'b1);
    checks++;
    if ({status, out_data} !== {5'b1_10_1_1, 8'hE0}) begin
      errors++;
      $display("FAIL gap_handoff got %b/%h want 11011/e0", status, out_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 2'b00;
    in_data = '0;
    in_last = 2'b00;
    out_ready = 1'b0;
    test_reset;
    test_single;
    test_simultaneous;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_valid_gap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
